// File: rtl/qsfp_link_ctrl.sv
// QSFP quad bring-up controller: sequences transceiver/core resets, waits for
// power-good and a debounced bonded link, retries on timeout, reports status.
module qsfp_link_ctrl #(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576,
    parameter int unsigned DEBOUNCE_CYCLES = 64,
    parameter int unsigned MAX_RETRIES     = 8
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        enable,
    input  logic        gt_pg,
    input  logic [3:0]  lane_up,
    input  logic        channel_up,
    output logic        gt_reset,
    output logic        sys_reset,
    output logic        link_ready,
    output logic        fail,
    output logic [2:0]  state,
    output logic [7:0]  retry_count,
    output logic [15:0] link_down_count
);

    localparam int unsigned CNT_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST       = 3'd1,
        S_WAIT_PG   = 3'd2,
        S_WAIT_LINK = 3'd3,
        S_UP        = 3'd4,
        S_RETRY     = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [7:0]    retry_q, retry_d;
    logic [15:0]   ldc_q, ldc_d;
    logic          gt_reset_q, gt_reset_d;
    logic          sys_reset_q, sys_reset_d;
    logic          link_ready_q, link_ready_d;
    logic          fail_q, fail_d;
    logic          link_good;

    assign link_good = (&lane_up) && channel_up;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        deb_d   = '0;
        retry_d = retry_q;
        ldc_d   = ldc_q;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                S_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_PG;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_PG: begin
                    if (gt_pg) begin
                        state_d = S_WAIT_LINK;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_RETRY;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LINK: begin
                    // Loss of power-good aborts first; a completed debounce beats a same-cycle timeout.
                    deb_d = link_good ? deb_q + DW'(1) : '0;
                    if (!gt_pg) begin
                        state_d = S_RETRY;
                        cnt_d   = '0;
                        deb_d   = '0;
                    end else if (link_good && (deb_q == DEB_LAST)) begin
                        state_d = S_UP;
                        cnt_d   = '0;
                        deb_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_RETRY;
                        cnt_d   = '0;
                        deb_d   = '0;
                    end
                end
                S_UP: begin
                    cnt_d = '0;
                    if (!link_good || !gt_pg) begin
                        state_d = S_RST;
                        if (ldc_q != '1) begin
                            ldc_d = ldc_q + 16'd1;
                        end
                    end
                end
                S_RETRY: begin
                    cnt_d   = '0;
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_RST;
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        gt_reset_d   = !(state_d inside {S_WAIT_PG, S_WAIT_LINK, S_UP});
        sys_reset_d  = !(state_d inside {S_WAIT_LINK, S_UP});
        link_ready_d = (state_d == S_UP);
        fail_d       = (state_d == S_FAIL);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            deb_q        <= '0;
            retry_q      <= '0;
            ldc_q        <= '0;
            gt_reset_q   <= 1'b1;
            sys_reset_q  <= 1'b1;
            link_ready_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            deb_q        <= deb_d;
            retry_q      <= retry_d;
            ldc_q        <= ldc_d;
            gt_reset_q   <= gt_reset_d;
            sys_reset_q  <= sys_reset_d;
            link_ready_q <= link_ready_d;
            fail_q       <= fail_d;
        end
    end

    assign gt_reset        = gt_reset_q;
    assign sys_reset       = sys_reset_q;
    assign link_ready      = link_ready_q;
    assign fail            = fail_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign link_down_count = ldc_q;

endmodule

// File: tb/tb_qsfp_link_ctrl.sv
// Bench for qsfp_link_ctrl: timestamp-based reference model compared every
// cycle, directed bring-up scenarios with literal expectations, random soak.
module tb_qsfp_link_ctrl;

    localparam int RC  = 8;
    localparam int TO  = 64;
    localparam int DEB = 4;
    localparam int MR  = 3;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        gt_pg = 1'b0;
    logic [3:0]  lane_up = 4'h0;
    logic        channel_up = 1'b0;
    logic        gt_reset, sys_reset, link_ready, fail;
    logic [2:0]  state;
    logic [7:0]  retry_count;
    logic [15:0] link_down_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    qsfp_link_ctrl #(
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_RETRIES    (MR)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .enable         (enable),
        .gt_pg          (gt_pg),
        .lane_up        (lane_up),
        .channel_up     (channel_up),
        .gt_reset       (gt_reset),
        .sys_reset      (sys_reset),
        .link_ready     (link_ready),
        .fail           (fail),
        .state          (state),
        .retry_count    (retry_count),
        .link_down_count(link_down_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time spent in a phase comes from edge timestamps, the
    // debounce run from the timestamp of the last non-good cycle.
    int m_state = 0, m_enter = 0, m_lastbad = 0, m_retry = 0, m_ldc = 0, cyc = 0;
    int m_el, m_nxt;
    bit m_good;

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_state   = 0;
            m_retry   = 0;
            m_ldc     = 0;
            m_enter   = cyc;
            m_lastbad = cyc;
        end else begin
            cyc++;
            m_el   = cyc - m_enter;
            m_good = (lane_up == 4'hF) && channel_up;
            m_nxt  = m_state;
            if (!enable) m_nxt = 0;
            else begin
                case (m_state)
                    0: begin m_nxt = 1; m_retry = 0; end
                    1: if (m_el >= RC) m_nxt = 2;
                    2: if (gt_pg) m_nxt = 3; else if (m_el >= TO) m_nxt = 5;
                    3: begin
                        if (!m_good) m_lastbad = cyc;
                        if (!gt_pg) m_nxt = 5;
                        else if (cyc - m_lastbad >= DEB) m_nxt = 4;
                        else if (m_el >= TO) m_nxt = 5;
                    end
                    4: if (!m_good || !gt_pg) begin
                        m_nxt = 1;
                        if (m_ldc < 65535) m_ldc++;
                    end
                    5: begin m_retry++; m_nxt = (m_retry == MR) ? 6 : 1; end
                    default: ;
                endcase
            end
            if (m_nxt != m_state) begin
                m_enter   = cyc;
                m_lastbad = cyc;
            end
            m_state = m_nxt;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("state",      int'(state),           m_state);
            check("gt_reset",   int'(gt_reset),        int'(m_state inside {0, 1, 5, 6}));
            check("sys_reset",  int'(sys_reset),       int'(!(m_state inside {3, 4})));
            check("link_ready", int'(link_ready),      int'(m_state == 4));
            check("fail",       int'(fail),            int'(m_state == 6));
            check("retry_cnt",  int'(retry_count),     m_retry);
            check("ldc",        int'(link_down_count), m_ldc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic link_good(input bit g);
        lane_up    = g ? 4'hF : 4'h0;
        channel_up = g;
    endtask

    int pg_pct[8] = '{99, 95, 0, 99, 50, 100, 0, 90};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(2);
        check("rst_state", int'(state), 0);
        check("rst_gt_reset", int'(gt_reset), 1);
        check("rst_sys_reset", int'(sys_reset), 1);
        check("rst_link_ready", int'(link_ready), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_retry", int'(retry_count), 0);
        check("rst_ldc", int'(link_down_count), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Nominal bring-up
        enable = 1'b1; gt_pg = 1'b0; link_good(1'b1);
        tick(1);  check("nom_rst_entry", int'(state), 1);
        tick(7);  check("nom_rst_hold", int'(state), 1);
                  check("nom_gt_reset_held", int'(gt_reset), 1);
        tick(1);  check("nom_wait_pg", int'(state), 2);
                  check("nom_gt_reset_fall", int'(gt_reset), 0);
                  check("nom_sys_reset_held", int'(sys_reset), 1);
        tick(5);  check("nom_still_wait_pg", int'(state), 2);
        gt_pg = 1'b1;
        tick(1);  check("nom_wait_link", int'(state), 3);
                  check("nom_sys_reset_fall", int'(sys_reset), 0);
        tick(3);  check("nom_debouncing", int'(state), 3);
        tick(1);  check("nom_up", int'(state), 4);
                  check("nom_link_ready", int'(link_ready), 1);

        // Link drop in UP
        lane_up = 4'hE;
        tick(1);  check("drop_state", int'(state), 1);
                  check("drop_link_ready", int'(link_ready), 0);
                  check("drop_ldc", int'(link_down_count), 1);
                  check("drop_retry", int'(retry_count), 0);
        lane_up = 4'hF;

        // Debounce glitch
        tick(8);  check("gl_wait_pg", int'(state), 2);
        tick(1);  check("gl_wait_link", int'(state), 3);
        tick(3);  check("gl_three_good", int'(state), 3);
        channel_up = 1'b0;
        tick(1);  check("gl_glitch", int'(state), 3);
        channel_up = 1'b1;
        tick(3);  check("gl_restart", int'(state), 3);
        tick(1);  check("gl_up", int'(state), 4);

        // Power-good on the last WAIT_PG cycle beats the timeout
        gt_pg = 1'b0;
        tick(1);  check("sim_rst", int'(state), 1);
                  check("sim_ldc", int'(link_down_count), 2);
        tick(8);  check("sim_wait_pg", int'(state), 2);
        tick(63); check("sim_wait_pg_63", int'(state), 2);
        gt_pg = 1'b1;
        tick(1);  check("sim_wait_link", int'(state), 3);
                  check("sim_retry", int'(retry_count), 0);

        // Async reset pulse mid-WAIT_LINK
        #1 rst = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_gt_reset", int'(gt_reset), 1);
        check("arst_sys_reset", int'(sys_reset), 1);
        check("arst_ldc", int'(link_down_count), 0);
        check("arst_retry", int'(retry_count), 0);
        rst   = 1'b0;
        gt_pg = 1'b0;

        // Never power-good: three timeouts then FAIL
        tick(1);   check("npg_rst", int'(state), 1);
        tick(218); check("npg_retry_state", int'(state), 5);
                   check("npg_retry_2", int'(retry_count), 2);
        tick(1);   check("npg_fail_state", int'(state), 6);
                   check("npg_retry_3", int'(retry_count), 3);
                   check("npg_fail", int'(fail), 1);
        tick(5);   check("npg_fail_hold", int'(state), 6);
        enable = 1'b0;
        tick(1);   check("npg_idle", int'(state), 0);
                   check("npg_fail_drop", int'(fail), 0);
                   check("npg_retry_kept", int'(retry_count), 3);
        enable = 1'b1;
        tick(1);   check("npg_retry_clear", int'(retry_count), 0);

        // Random soak against the model
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 500; i++) begin
                tick(1);
                rst    = ($urandom_range(0, 999) == 0);
                enable = ($urandom_range(0, 299) != 0);
                gt_pg  = ($urandom_range(0, 99) < pg_pct[s]);
                if ($urandom_range(0, 99) < 93) link_good(1'b1);
                else begin
                    lane_up    = 4'($urandom_range(0, 15));
                    channel_up = 1'($urandom_range(0, 1));
                end
            end
        end
        rst = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qsfp_link_ctrl.md
QSFP_LINK_CTRL -- requirements
Module: qsfp_link_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles both resets are held in RST.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycle limit for each WAIT_PG and WAIT_LINK attempt.
REQ-003 Parameter DEBOUNCE_CYCLES, default 64: consecutive cycles of full link required before UP.
REQ-004 Parameter MAX_RETRIES, default 8, range 1..255: failed attempts allowed before FAIL.
REQ-005 Port CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port enable, input, 1: link bring-up request; low forces IDLE.
REQ-008 Port gt_pg, input, 1: transceiver power-good for the 4-lane QSFP quad.
REQ-009 Port lane_up, input, 4: per-lane up status.
REQ-010 Port channel_up, input, 1: bonded channel up.
REQ-011 Port gt_reset, output, 1: transceiver reset, active-high.
REQ-012 Port sys_reset, output, 1: link core reset, active-high.
REQ-013 Port link_ready, output, 1: link is usable by the datapath.
REQ-014 Port fail, output, 1: retries exhausted.
REQ-015 Port state, output, 3: current state encoding.
REQ-016 Port retry_count, output, 8: failed attempts since the last IDLE.
REQ-017 Port link_down_count, output, 16: UP-to-down events, saturating at 16'hFFFF.
REQ-018 Inputs are already synchronous to CLK; no synchronizers are required in this block.

Function
REQ-019 States and encodings SHALL be IDLE=0, RST=1, WAIT_PG=2, WAIT_LINK=3, UP=4, RETRY=5, FAIL=6. All outputs are registered.
REQ-020 IDLE: gt_reset=1, sys_reset=1. When enable=1, next state is RST, the cycle counter clears, and retry_count clears to 0.
REQ-021 RST: gt_reset=1, sys_reset=1. After exactly RESET_CYCLES cycles in RST, next state is WAIT_PG.
REQ-022 WAIT_PG: gt_reset=0, sys_reset=1.
- gt_pg=1 -> WAIT_LINK, counter cleared.
- Otherwise, on the TIMEOUT_CYCLES-th cycle -> RETRY.
REQ-023 WAIT_LINK: gt_reset=0, sys_reset=0.
- The debounce counter increments while lane_up==4'hF && channel_up==1, and clears on any other cycle.
- Reaching DEBOUNCE_CYCLES -> UP.
- Otherwise, TIMEOUT_CYCLES elapsed -> RETRY.
- gt_pg=0 -> RETRY immediately.
REQ-024 UP: link_ready=1, both resets 0. Any of lane_up!=4'hF, channel_up=0 or gt_pg=0 -> RST in the next cycle, link_down_count +1 (saturating), link_ready=0 in that same cycle.
REQ-025 RETRY lasts one cycle with both resets=1, and increments retry_count. If the new value equals MAX_RETRIES -> FAIL, else -> RST.
REQ-026 FAIL: fail=1, gt_reset=1, sys_reset=1, held until enable=0.
REQ-027 enable=0 in any state -> IDLE on the next edge, with gt_reset=1 and sys_reset=1 in that cycle. link_ready and fail drop in the same cycle. Counts are kept, except that retry_count clears on leaving IDLE.
REQ-028 link_ready=1 only in UP; fail=1 only in FAIL.
REQ-029 If timeout and success occur in the same cycle, success wins (WAIT_PG->WAIT_LINK, WAIT_LINK->UP).
REQ-030 UP-to-RST re-entry SHALL NOT increment retry_count.
REQ-031 Counters are wide enough for their parameters. The cycle counter does not wrap before the timeout fires.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE, gt_reset=1, sys_reset=1, link_ready=0, fail=0, retry_count=0, link_down_count=0, all internal counters 0.
REQ-033 Reset deassertion mid-operation restarts from IDLE; the first transition is on the first edge with rst=0 and enable=1.

Verification (RESET_CYCLES=8, TIMEOUT_CYCLES=64, DEBOUNCE_CYCLES=4, MAX_RETRIES=3)
REQ-034 Nominal bring-up: enable=1; gt_pg rises 5 cycles into WAIT_PG; lane_up=F and channel_up=1 held -> gt_reset falls 8 cycles after RST entry, link_ready=1 after 4 debounce cycles, state=4.
REQ-035 Debounce glitch: channel_up drops for 1 cycle after 3 good cycles -> debounce restarts; UP is reached 4 cycles after the link is restored.
REQ-036 Never power-good: gt_pg=0 throughout -> 3 timeouts of 64 cycles, retry_count=3, fail=1, state=6; then enable=0 -> IDLE, fail=0.
REQ-037 Link drop in UP: lane_up=4'hE for 1 cycle -> next cycle state=1, link_ready=0, link_down_count=1, retry_count unchanged.
REQ-038 Async reset mid-WAIT_LINK: rst pulses between clock edges -> outputs reach reset values immediately, without waiting for an edge; counts are 0.
REQ-039 Simultaneous events: gt_pg rises on the 64th WAIT_PG cycle -> WAIT_LINK is entered and retry_count stays 0.
